riscv_div: RTL and testbench
============================

// Module: riscv_div
// PURPOSE
//  Multi-cycle radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU ops, located in the EX stage.
//  - Raises req_ex toward the stall controller while it is working, which freezes IF/ID/EX.
//  - Returns one 32-bit result to the EX result mux as a single-cycle valid pulse.
// PARAMETERS
//  XLEN   32   operand/result width; iteration count = XLEN; counter width = $clog2(XLEN)+1
// PORTS
//  clk        in   1     single clock, rising edge
//  rst        in   1     synchronous, active-low reset (asserted when 0)
//  start      in   1     divide op present in EX; held high while stalled
//  annul      in   1     flush of the EX op; cancels any operation
//  op         in   2     `DIV_OP_DIV / `DIV_OP_DIVU / `DIV_OP_REM / `DIV_OP_REMU
//  dividend   in   XLEN  rs1 value; sampled only on accept
//  divisor    in   XLEN  rs2 value; sampled only on accept
//  result     out  XLEN  quotient or remainder; valid only while valid=1
//  valid      out  1     one-cycle completion pulse
//  req_ex     out  1     stall request to the stall controller (EX-stage request)
// BEHAVIOUR
//  Reset (rst=0 at an edge): state=IDLE, result=0, valid=0, req_ex=0, counter=0.
//  - Reset wins over all other inputs, including mid-operation.
//  States: IDLE, BUSY, DONE.
//  IDLE:
//  - Accept when start=1 and annul=0. req_ex=1 combinationally in the accept cycle, so the stall takes effect at once.
//  - On accept, latch op, sign flags, |dividend|, |divisor|. Signed ops use two's-complement magnitude; 0x80000000 stays 0x80000000 as unsigned.
//  - Next state is BUSY, count=XLEN.
//  BUSY:
//  - req_ex=1. Each cycle does one shift/trial-subtract step, {rem,quo} <<1; if rem>=divisor then rem-=divisor and set the quo LSB.
//  - count decrements; at count==1 the next state is DONE.
//  DONE:
//  - valid=1, req_ex=0, and result is driven. The pipeline advances at this edge. Next state is IDLE.
//  - start is still high in this cycle from the old op; it is ignored.
//  Latency: accept cycle T, valid at T+XLEN+1. req_ex is high for XLEN+1 cycles (T..T+XLEN).
//  Back-to-back divides: a new start is accepted in the IDLE cycle right after DONE.
//  Sign correction, applied in DONE:
//  - Quotient is negated if signs differ (DIV only).
//  - Remainder takes the dividend's sign (REM only).
//  Special cases (RISC-V spec):
//  - x/0: quo=0xFFFFFFFF, rem=x.
//  - DIV 0x80000000/-1: quo=0x80000000, rem=0.
//  - These override the normal correction.
//  annul:
//  - In any state, forces next state IDLE and drives req_ex=0 and valid=0 in the same cycle.
//  - annul together with start in IDLE means no accept.
//  result holds its last value when valid=0. Consumers must ignore it then.
// CONFIGURATION
//  `RISCV_DIV_FASTPATH_EN defined:
//  - Divide-by-zero and signed overflow are detected on accept and go IDLE->DONE.
//  - req_ex is high 1 cycle and valid arrives at T+1.
//  Undefined:
//  - These cases run the full XLEN iterations.
//  - Identical special-case results are forced in DONE.
// STRUCTURE
//  - `DIV_OP_* encodings (2 bits) go in the shared riscv_define.v, next to the stall bit definitions.
//  - State encodings are local.
//  - Optional sub-module riscv_div_step: combinational single iteration (rem,quo,divisor)->(rem',quo'). The FSM and sign logic stay in riscv_div.
// TESTING
//  1. DIVU 100/7, start at T: req_ex=1 for T..T+32, valid=1 and result=14 at T+33, req_ex=0 at T+33.
//  2. DIV -7/2 -> 0xFFFFFFFD; REM -7%2 -> 0xFFFFFFFF; REMU 0xFFFFFFF9%2 -> 1.
//  3. DIV 0x80000000/0 -> 0xFFFFFFFF; REM -> 0x80000000. With _FASTPATH_EN valid at T+1, else at T+33.
//  4. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0. Back-to-back second op accepted the cycle after the first DONE.
//  5. annul at T+10: req_ex=0 in that cycle, no valid pulse, state IDLE at T+11. New start at T+11 gives a correct result at T+44.
//  6. rst=0 at T+5 mid-BUSY: all outputs 0 after the edge. After release, start is held high but no result appears until a fresh accept.

Source files
------------

// File: rtl/riscv_div_pkg.sv
// Shared types for the RV32M divider: op encodings, FSM states and op helpers.
// Optional feature macro used by riscv_div: RISCV_DIV_FASTPATH_EN.
package riscv_div_pkg;

    localparam int DIV_XLEN = 32;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } div_state_e;

    function automatic logic op_is_signed(div_op_e op);
        return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    endfunction

    function automatic logic op_is_rem(div_op_e op);
        return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
    endfunction

endpackage

// File: rtl/riscv_div_if.sv
// EX-stage divider handshake: op request from the pipeline, result/valid/stall back.
interface riscv_div_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            annul;
    logic [1:0]      op;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic [XLEN-1:0] result;
    logic            valid;
    logic            req_ex;

    modport master (
        output start, annul, op, dividend, divisor,
        input  result, valid, req_ex
    );

    modport slave (
        input  start, annul, op, dividend, divisor,
        output result, valid, req_ex
    );
endinterface

// File: rtl/riscv_div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract divisor.
module riscv_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // The extra top bit of diff is the borrow: set means rem < divisor.
    always_comb begin
        shifted = {rem, quo[XLEN-1]};
        diff    = shifted - {1'b0, divisor};
        if (!diff[XLEN]) begin
            rem_next = diff[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b1};
        end else begin
            rem_next = shifted[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/riscv_div.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU in EX.
// Define RISCV_DIV_FASTPATH_EN to finish x/0 and signed overflow in one cycle.
//
//  state   | meaning
//  --------+---------------------------------------------------------
//  ST_IDLE | waiting for start; accept cycle raises req_ex
//  ST_BUSY | one shift/subtract step per cycle, count runs XLEN..1
//  ST_DONE | sign-corrected result driven with a one-cycle valid
module riscv_div
    import riscv_div_pkg::*;
#(
    parameter int XLEN = DIV_XLEN
) (
    input logic         clk,
    input logic         rst,
    riscv_div_if.slave  bus
);
    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      state;
    div_state_e      state_next;
    logic [CNT_W-1:0] count;

    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] dvsr;
    logic [XLEN-1:0] dvd_raw;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] quo_next;
    logic [XLEN-1:0] result_hold;
    logic [XLEN-1:0] final_val;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;

    logic            is_rem;
    logic            neg_quo;
    logic            neg_rem;
    logic            div_zero;
    logic            ovf;

    div_op_e         op_in;
    logic            in_signed;
    logic            dvd_neg;
    logic            dvs_neg;
    logic            in_zero;
    logic            in_ovf;
    logic [XLEN-1:0] dvd_mag;
    logic [XLEN-1:0] dvs_mag;

    logic            load;
    logic            step_en;
    logic            req_ex;
    logic            valid;

    // Operand decode, only consumed in the accept cycle.
    always_comb begin
        op_in     = div_op_e'(bus.op);
        in_signed = op_is_signed(op_in);
        dvd_neg   = in_signed & bus.dividend[XLEN-1];
        dvs_neg   = in_signed & bus.divisor[XLEN-1];
        dvd_mag   = dvd_neg ? -bus.dividend : bus.dividend;
        dvs_mag   = dvs_neg ? -bus.divisor  : bus.divisor;
        in_zero   = (bus.divisor == '0);
        in_ovf    = in_signed & (bus.dividend == MOST_NEG) & (&bus.divisor);
    end

    riscv_div_step #(.XLEN(XLEN)) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (dvsr),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ex     = 1'b0;
        valid      = 1'b0;
        load       = 1'b0;
        step_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                // Gated by rst so no stall is requested from a cycle being reset.
                if (rst && bus.start && !bus.annul) begin
                    req_ex     = 1'b1;
                    load       = 1'b1;
                    state_next = ST_BUSY;
`ifdef RISCV_DIV_FASTPATH_EN
                    if (in_zero || in_ovf) begin
                        state_next = ST_DONE;
                    end
`endif
                end
            end
            ST_BUSY: begin
                if (bus.annul) begin
                    state_next = ST_IDLE;
                end else begin
                    req_ex  = 1'b1;
                    step_en = 1'b1;
                    if (count == CNT_W'(1)) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                valid      = !bus.annul;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count       <= '0;
            rem         <= '0;
            quo         <= '0;
            dvsr        <= '0;
            dvd_raw     <= '0;
            is_rem      <= 1'b0;
            neg_quo     <= 1'b0;
            neg_rem     <= 1'b0;
            div_zero    <= 1'b0;
            ovf         <= 1'b0;
            result_hold <= '0;
        end else begin
            if (load) begin
                count    <= CNT_W'(XLEN);
                rem      <= '0;
                quo      <= dvd_mag;
                dvsr     <= dvs_mag;
                dvd_raw  <= bus.dividend;
                is_rem   <= op_is_rem(op_in);
                neg_quo  <= (op_in == DIV_OP_DIV) & (dvd_neg ^ dvs_neg);
                neg_rem  <= (op_in == DIV_OP_REM) & dvd_neg;
                div_zero <= in_zero;
                ovf      <= in_ovf;
            end else if (step_en) begin
                count <= count - 1'b1;
                rem   <= rem_next;
                quo   <= quo_next;
            end
            if (valid) begin
                result_hold <= final_val;
            end
        end
    end

    // Special cases override the normal sign correction; overflow quotient equals the dividend.
    always_comb begin
        quo_fix = neg_quo ? -quo : quo;
        rem_fix = neg_rem ? -rem : rem;
        if (div_zero) begin
            quo_fix = '1;
            rem_fix = dvd_raw;
        end else if (ovf) begin
            quo_fix = dvd_raw;
            rem_fix = '0;
        end
        final_val = is_rem ? rem_fix : quo_fix;
    end

    assign bus.req_ex = req_ex;
    assign bus.valid  = valid;
    assign bus.result = (state == ST_DONE) ? final_val : result_hold;

endmodule

// File: tb/tb_riscv_div.sv
// Self-checking bench for riscv_div: directed RV32M cases plus random ops vs. an arithmetic model.
module tb_riscv_div;
    import riscv_div_pkg::*;

`ifdef RISCV_DIV_FASTPATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    riscv_div_if #(.XLEN(32)) bus ();

    riscv_div #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input div_op_e op, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = int'(a);
        sb = int'(b);
        case (op)
            DIV_OP_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            DIV_OP_DIVU: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            DIV_OP_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sb);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_lat(input div_op_e op, input logic [31:0] a, input logic [31:0] b);
        logic sgn;
        logic special;
        sgn     = (op == DIV_OP_DIV) || (op == DIV_OP_REM);
        special = (b == 0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        return (FAST && special) ? 1 : 33;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(1, 15));
            4:       return 32'(-int'($urandom_range(1, 15)));
            default: return $urandom();
        endcase
    endfunction

    // Tasks start and end just after a rising edge; outputs are sampled at the falling edge.
    task automatic do_reset(input int n);
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.annul = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic run_op(input string name, input div_op_e op, input logic [31:0] a, input logic [31:0] b);
        int          lat_exp;
        logic [31:0] exp;
        int          lat;
        int          req_total;
        logic        req_at_valid;
        logic [31:0] got;
        lat_exp      = ref_lat(op, a, b);
        exp          = ref_div(op, a, b);
        lat          = -1;
        req_total    = 0;
        req_at_valid = 1'b0;
        got          = 32'h0;
        bus.op       = op;
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        bus.annul    = 1'b0;
        @(negedge clk);
        chk({name, ".accept_req"}, 32'(bus.req_ex), 32'd1);
        chk({name, ".idle_valid"}, 32'(bus.valid), 32'd0);
        if (bus.req_ex) req_total = 1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            if (bus.valid) begin
                lat          = c;
                got          = bus.result;
                req_at_valid = bus.req_ex;
                break;
            end
            if (bus.req_ex) req_total++;
        end
        chk({name, ".latency"}, 32'(lat), 32'(lat_exp));
        chk({name, ".req_cycles"}, 32'(req_total), 32'(lat_exp));
        chk({name, ".req_at_valid"}, 32'(req_at_valid), 32'd0);
        chk({name, ".result"}, got, exp);
        @(posedge clk);
        #1;
        if (lat < 0) do_reset(2);
    endtask

    task automatic idle(input int n);
        bus.start = 1'b0;
        bus.annul = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int valid_cnt;
        int req_cnt;
        bus.start    = 1'b0;
        bus.annul    = 1'b0;
        bus.op       = 2'b00;
        bus.dividend = 32'h0;
        bus.divisor  = 32'h0;
        rst          = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        @(negedge clk);
        chk("reset.result", bus.result, 32'h0);
        chk("reset.valid", 32'(bus.valid), 32'd0);
        chk("reset.req_ex", 32'(bus.req_ex), 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        bus.start = 1'b0;
        idle(1);

        run_op("divu_100_7", DIV_OP_DIVU, 32'd100, 32'd7);
        idle(1);

        run_op("div_m7_2", DIV_OP_DIV, 32'hFFFF_FFF9, 32'd2);
        run_op("rem_m7_2", DIV_OP_REM, 32'hFFFF_FFF9, 32'd2);
        run_op("remu_fff9_2", DIV_OP_REMU, 32'hFFFF_FFF9, 32'd2);
        idle(2);

        run_op("div_min_0", DIV_OP_DIV, 32'h8000_0000, 32'h0);
        run_op("rem_min_0", DIV_OP_REM, 32'h8000_0000, 32'h0);
        run_op("divu_7_0", DIV_OP_DIVU, 32'd7, 32'h0);
        run_op("remu_7_0", DIV_OP_REMU, 32'd7, 32'h0);
        run_op("div_min_m1", DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem_min_m1", DIV_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu_min_m1", DIV_OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(1);

        // annul ten cycles into an operation, then a fresh op the next cycle
        bus.op       = DIV_OP_DIVU;
        bus.dividend = 32'd1000;
        bus.divisor  = 32'd3;
        bus.start    = 1'b1;
        @(negedge clk);
        chk("annul.accept_req", 32'(bus.req_ex), 32'd1);
        valid_cnt = 0;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            if (bus.valid) valid_cnt++;
        end
        @(posedge clk);
        #1;
        bus.annul = 1'b1;
        @(negedge clk);
        chk("annul.req_ex", 32'(bus.req_ex), 32'd0);
        chk("annul.valid", 32'(bus.valid), 32'd0);
        chk("annul.no_early_valid", 32'(valid_cnt), 32'd0);
        @(posedge clk);
        #1;
        run_op("after_annul", DIV_OP_DIV, 32'(-1000), 32'd7);
        idle(1);

        // synchronous reset in the middle of BUSY with start held high
        bus.op       = DIV_OP_DIVU;
        bus.dividend = 32'd12345;
        bus.divisor  = 32'd11;
        bus.start    = 1'b1;
        @(negedge clk);
        chk("rst_mid.accept_req", 32'(bus.req_ex), 32'd1);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_mid.result", bus.result, 32'h0);
        chk("rst_mid.valid", 32'(bus.valid), 32'd0);
        chk("rst_mid.req_ex", 32'(bus.req_ex), 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        bus.start = 1'b0;
        valid_cnt = 0;
        req_cnt   = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.valid) valid_cnt++;
            if (bus.req_ex) req_cnt++;
            @(posedge clk);
            #1;
        end
        chk("rst_mid.no_valid_after", 32'(valid_cnt), 32'd0);
        chk("rst_mid.no_req_after", 32'(req_cnt), 32'd0);
        run_op("after_rst", DIV_OP_DIVU, 32'd12345, 32'd11);

        for (int i = 0; i < 50; i++) begin
            div_op_e     op;
            logic [31:0] a;
            logic [31:0] b;
            op = div_op_e'(2'($urandom_range(0, 3)));
            a  = pick();
            b  = pick();
            run_op($sformatf("rand%0d", i), op, a, b);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
